// File: rtl/cic_pkg.sv
// Shared constants and helpers for the CIC integrator/decimator slice.
// Holds the default configuration and the accumulator width calculation.
package cic_pkg;

  localparam int unsigned CIC_DEF_STAGES    = 32'd5;
  localparam int unsigned CIC_DEF_IN_WIDTH  = 32'd24;
  localparam int unsigned CIC_DEF_WIDTH     = 32'd64;
  localparam int unsigned CIC_DEF_RATE_BITS = 32'd10;

  // Smallest n with 2**n >= v (0 for v <= 1).
  function automatic int unsigned cic_ceil_log2(input int unsigned v);
    int unsigned res;
    res = 32'd0;
    for (int i = 0; i < 32; i++) begin
      if ((32'd1 << i) < v) begin
        res = 32'(i) + 32'd1;
      end else begin
        res = res;
      end
    end
    return res;
  endfunction

  // Accumulator width that cannot lose information for decimation up to r_max.
  function automatic int unsigned cic_required_width(input int unsigned in_width,
                                                     input int unsigned stages,
                                                     input int unsigned r_max);
    return in_width + stages * cic_ceil_log2(r_max);
  endfunction

endpackage

// File: rtl/cic_integrator.sv
// Single strobe-gated integrator stage: acc <= acc + din when en is high.
// Wraps modulo 2**WIDTH by design; CIC correctness relies on the wrap.
module cic_integrator
  import cic_pkg::*;
#(
  parameter int WIDTH = CIC_DEF_WIDTH
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             en,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] acc
);

  logic [WIDTH-1:0] acc_d;
  logic [WIDTH-1:0] acc_q;

  // Next accumulator value: add on strobe, otherwise hold.
  always_comb begin
    acc_d = acc_q;
    if (en) begin
      acc_d = acc_q + din;
    end else begin
      acc_d = acc_q;
    end
  end

  // Accumulator register with asynchronous clear.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      acc_q <= {WIDTH{1'b0}};
    end else begin
      acc_q <= acc_d;
    end
  end

  assign acc = acc_q;

endmodule

// File: rtl/cic_integrator_decimator.sv
// CIC integrator cascade followed by the decimation (rate) stage.
// Optional macro CIC_INT_INREG_EN registers in_strobe/in_data in front of
// the first integrator, adding one clock of latency.
module cic_integrator_decimator
  import cic_pkg::*;
#(
  parameter int STAGES    = CIC_DEF_STAGES,
  parameter int IN_WIDTH  = CIC_DEF_IN_WIDTH,
  parameter int WIDTH     = CIC_DEF_WIDTH,
  parameter int RATE_BITS = CIC_DEF_RATE_BITS
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic                       in_strobe,
  input  logic signed [IN_WIDTH-1:0] in_data,
  input  logic        [RATE_BITS-1:0] rate,
  output logic                       out_strobe,
  output logic signed [WIDTH-1:0]    out_data
);

  localparam logic [RATE_BITS-1:0] RATE_ONE = RATE_BITS'(1'b1);

  logic                       stage_stb;
  logic signed [IN_WIDTH-1:0] stage_in;
  logic        [WIDTH-1:0]    ext_in;
  logic        [WIDTH-1:0]    acc [STAGES];

`ifdef CIC_INT_INREG_EN
  logic                       stb_in_d;
  logic                       stb_in_q;
  logic signed [IN_WIDTH-1:0] dat_in_d;
  logic signed [IN_WIDTH-1:0] dat_in_q;

  // Input capture: the retimed strobe/data pair feeds the cascade.
  always_comb begin
    stb_in_d = in_strobe;
    dat_in_d = in_data;
  end

  // Input register stage with asynchronous clear.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      stb_in_q <= 1'b0;
      dat_in_q <= {IN_WIDTH{1'b0}};
    end else begin
      stb_in_q <= stb_in_d;
      dat_in_q <= dat_in_d;
    end
  end

  assign stage_stb = stb_in_q;
  assign stage_in  = dat_in_q;
`else
  assign stage_stb = in_strobe;
  assign stage_in  = in_data;
`endif

  // Signed cast sign-extends the sample to accumulator width.
  assign ext_in = WIDTH'(stage_in);

  // Integrator cascade: each stage adds the previous stage's pre-edge value.
  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    logic [WIDTH-1:0] din;
    if (k == 0) begin : g_first
      assign din = ext_in;
    end else begin : g_chain
      assign din = acc[k-1];
    end
    cic_integrator #(.WIDTH(WIDTH)) u_int (
      .clock (clock),
      .reset (reset),
      .en    (stage_stb),
      .din   (din),
      .acc   (acc[k])
    );
  end

  logic [RATE_BITS-1:0] cnt_d, cnt_q;
  logic [RATE_BITS-1:0] r_act_d, r_act_q;
  logic                 r_pend_d, r_pend_q;
  logic                 out_strobe_d, out_strobe_q;
  logic [WIDTH-1:0]     out_data_d, out_data_q;
  logic [RATE_BITS-1:0] rate_clamped;
  logic [RATE_BITS-1:0] r_eff;

  // Decimation control. After reset r_pend_q is set, so the frame length
  // tracks the live (clamped) rate until the first strobe fixes it; after
  // that the rate is only re-sampled on the strobe that closes a frame.
  always_comb begin
    cnt_d        = cnt_q;
    r_act_d      = r_act_q;
    r_pend_d     = r_pend_q;
    out_strobe_d = 1'b0;
    out_data_d   = out_data_q;
    rate_clamped = rate;
    r_eff        = r_act_q;

    if (rate > RATE_ONE) begin
      rate_clamped = rate;
    end else begin
      rate_clamped = RATE_ONE;
    end

    if (r_pend_q) begin
      r_eff = rate_clamped;
    end else begin
      r_eff = r_act_q;
    end

    if (stage_stb) begin
      r_pend_d = 1'b0;
      // >= keeps the counter bounded even if it were ever corrupted.
      if (cnt_q >= (r_eff - RATE_ONE)) begin
        cnt_d        = {RATE_BITS{1'b0}};
        r_act_d      = rate_clamped;
        out_strobe_d = 1'b1;
        out_data_d   = acc[STAGES-1];
      end else begin
        cnt_d   = cnt_q + RATE_ONE;
        r_act_d = r_eff;
      end
    end else begin
      cnt_d        = cnt_q;
      r_act_d      = r_act_q;
      out_strobe_d = 1'b0;
    end
  end

  // Control and output registers with asynchronous clear.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      cnt_q        <= {RATE_BITS{1'b0}};
      r_act_q      <= RATE_ONE;
      r_pend_q     <= 1'b1;
      out_strobe_q <= 1'b0;
      out_data_q   <= {WIDTH{1'b0}};
    end else begin
      cnt_q        <= cnt_d;
      r_act_q      <= r_act_d;
      r_pend_q     <= r_pend_d;
      out_strobe_q <= out_strobe_d;
      out_data_q   <= out_data_d;
    end
  end

  assign out_strobe = out_strobe_q;
  assign out_data   = out_data_q;

endmodule

// File: tb/tb_cic_integrator_decimator.sv
// Directed self-checking bench for cic_integrator_decimator.
// Three instances share stimulus: A (STAGES=1), B (STAGES=1, 8-bit), C (STAGES=5).
// Honors CIC_INT_INREG_EN by delaying each expectation by one step.
module tb_cic_integrator_decimator;

  logic        clock;
  logic        reset;
  logic        in_strobe;
  logic [23:0] in_data;
  logic [9:0]  rate;

  logic        a_stb;
  logic [63:0] a_dat;
  logic        b_stb;
  logic [7:0]  b_dat;
  logic        c_stb;
  logic [63:0] c_dat;

  int n_checks;
  int n_fails;

  logic [7:0]  b_hist [$];
  logic [63:0] binom [10];
  logic [7:0]  wrap8 [4];

`ifdef CIC_INT_INREG_EN
  int          pend_sel;
  logic        pend_stb;
  logic [63:0] pend_dat;
  string       pend_tag;
`endif

  cic_integrator_decimator #(.STAGES(1)) dut_a (
    .clock(clock), .reset(reset), .in_strobe(in_strobe), .in_data(in_data),
    .rate(rate), .out_strobe(a_stb), .out_data(a_dat));

  cic_integrator_decimator #(.STAGES(1), .IN_WIDTH(8), .WIDTH(8)) dut_b (
    .clock(clock), .reset(reset), .in_strobe(in_strobe), .in_data(in_data[7:0]),
    .rate(rate), .out_strobe(b_stb), .out_data(b_dat));

  cic_integrator_decimator dut_c (
    .clock(clock), .reset(reset), .in_strobe(in_strobe), .in_data(in_data),
    .rate(rate), .out_strobe(c_stb), .out_data(c_dat));

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Capture every decimated sample of instance B for the comb-difference check.
  always @(negedge clock) begin
    if (b_stb) b_hist.push_back(b_dat);
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fails++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic logic obs_stb(input int sel);
    case (sel)
      0:       return a_stb;
      1:       return b_stb;
      default: return c_stb;
    endcase
  endfunction

  function automatic logic [63:0] obs_dat(input int sel);
    case (sel)
      0:       return a_dat;
      1:       return {56'd0, b_dat};
      default: return c_dat;
    endcase
  endfunction

  task automatic compare_out(input int sel, input logic es, input logic [63:0] ed, input string tag);
    check({tag, "_stb"}, {63'd0, obs_stb(sel)}, {63'd0, es});
    if (es) check({tag, "_dat"}, obs_dat(sel), ed);
  endtask

  // One clock with the given inputs; es/ed are the outputs this strobe should cause.
  task automatic step(input logic s, input logic [23:0] d, input int sel,
                      input logic es, input logic [63:0] ed, input string tag);
    in_strobe = s;
    in_data   = d;
    @(posedge clock);
    #1;
`ifdef CIC_INT_INREG_EN
    compare_out(pend_sel, pend_stb, pend_dat, pend_tag);
    pend_sel = sel;
    pend_stb = es;
    pend_dat = ed;
    pend_tag = tag;
`else
    compare_out(sel, es, ed, tag);
`endif
  endtask

  // Asynchronous reset pulse taken mid-cycle; outputs must clear at once.
  task automatic do_reset(input logic [9:0] r);
    in_strobe = 1'b0;
    rate      = r;
    reset     = 1'b1;
    #2;
    check("rst_a_stb", {63'd0, a_stb}, 64'd0);
    check("rst_a_dat", a_dat, 64'd0);
    check("rst_b_stb", {63'd0, b_stb}, 64'd0);
    check("rst_b_dat", {56'd0, b_dat}, 64'd0);
    check("rst_c_stb", {63'd0, c_stb}, 64'd0);
    check("rst_c_dat", c_dat, 64'd0);
    @(posedge clock);
    #1;
    check("rst_hold_a_stb", {63'd0, a_stb}, 64'd0);
    reset = 1'b0;
`ifdef CIC_INT_INREG_EN
    pend_sel = 0;
    pend_stb = 1'b0;
    pend_dat = 64'd0;
    pend_tag = "post_rst";
`endif
  endtask

  initial begin
    n_checks  = 0;
    n_fails   = 0;
    reset     = 1'b1;
    in_strobe = 1'b0;
    in_data   = 24'd0;
    rate      = 10'd4;
    binom = '{64'd0, 64'd0, 64'd0, 64'd0, 64'd0, 64'd1, 64'd5, 64'd15, 64'd35, 64'd70};
    wrap8 = '{8'd100, 8'd44, 8'd244, 8'd188};

    // Reset state, then R=4 with continuous unit input: 3, 7, 11, 15.
    do_reset(10'd4);
    for (int i = 1; i <= 16; i++) begin
      step(1'b1, 24'd1, 0, ((i % 4) == 0), 64'(i - 1), "r4");
    end
    step(1'b0, 24'd0, 0, 1'b0, 64'd0, "r4_idle");
    step(1'b0, 24'd0, 0, 1'b0, 64'd0, "r4_idle2");
    check("r4_hold", a_dat, 64'd15);

    // rate = 0 behaves as R=1: every strobe yields an output.
    do_reset(10'd0);
    for (int i = 1; i <= 3; i++) begin
      step(1'b1, 24'd1, 0, 1'b1, 64'(i - 1), "rate0");
    end
    step(1'b0, 24'd0, 0, 1'b0, 64'd0, "rate0_idle");

    // 8-bit wrap: 100, 44, 244, 188 and comb differences of 200.
    do_reset(10'd2);
    b_hist.delete();
    for (int i = 1; i <= 8; i++) begin
      step(1'b1, 24'd100, 1, ((i % 2) == 0), ((i % 2) == 0) ? {56'd0, wrap8[i/2 - 1]} : 64'd0, "wrap8");
    end
    step(1'b0, 24'd0, 1, 1'b0, 64'd0, "wrap8_idle");
    check("wrap8_count", 64'(b_hist.size()), 64'd4);
    for (int k = 1; k < b_hist.size(); k++) begin
      logic [7:0] df;
      df = b_hist[k] - b_hist[k-1];
      check("comb_diff", {56'd0, df}, 64'd200);
    end

    // Rate change 4->8 mid-frame: this frame ends after 4, the next after 8.
    do_reset(10'd4);
    step(1'b1, 24'd1, 0, 1'b0, 64'd0, "rchg");
    step(1'b1, 24'd1, 0, 1'b0, 64'd0, "rchg");
    rate = 10'd8;
    step(1'b1, 24'd1, 0, 1'b0, 64'd0, "rchg");
    step(1'b1, 24'd1, 0, 1'b1, 64'd3, "rchg_end4");
    for (int i = 5; i <= 12; i++) begin
      step(1'b1, 24'd1, 0, (i == 12), 64'd11, "rchg_r8");
    end
    step(1'b0, 24'd0, 0, 1'b0, 64'd0, "rchg_idle");

    // Strobe every 3rd clock, R=2: outputs 6 clocks apart, values 1, 3, 5.
    do_reset(10'd2);
    begin
      int n;
      n = 0;
      for (int c = 0; c < 18; c++) begin
        logic s;
        s = ((c % 3) == 0);
        if (s) n++;
        step(s, 24'd1, 0, s && ((n % 2) == 0), 64'(n - 1), "sparse");
      end
    end
    step(1'b0, 24'd0, 0, 1'b0, 64'd0, "sparse_idle");

    // Reset after 3 of 4 strobes abandons the frame; next frame is a full 4.
    do_reset(10'd4);
    for (int i = 1; i <= 4; i++) begin
      step(1'b1, 24'd1, 0, (i == 4), 64'd3, "mid_pre");
    end
    for (int i = 1; i <= 3; i++) begin
      step(1'b1, 24'd1, 0, 1'b0, 64'd0, "mid_part");
    end
    check("mid_before_rst", a_dat, 64'd3);
    do_reset(10'd4);
    for (int i = 1; i <= 4; i++) begin
      step(1'b1, 24'd1, 0, (i == 4), 64'd3, "mid_post");
    end
    step(1'b0, 24'd0, 0, 1'b0, 64'd0, "mid_idle");

    // Five stages, R=1, unit impulse: binomial sequence 0,0,0,0,0,1,5,15,35,70.
    do_reset(10'd1);
    step(1'b1, 24'd1, 2, 1'b1, binom[0], "binom");
    for (int i = 2; i <= 10; i++) begin
      step(1'b1, 24'd0, 2, 1'b1, binom[i-1], "binom");
    end
    step(1'b0, 24'd0, 2, 1'b0, 64'd0, "binom_idle");
    check("binom_hold", c_dat, 64'd70);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule

// File: doc/cic_integrator_decimator.md
CIC_INTEGRATOR_DECIMATOR -- requirements
Module: cic_integrator_decimator

Interface
REQ-001 SHALL have parameter STAGES, default 5: number of cascaded integrator stages (1..8).
REQ-002 SHALL have parameter IN_WIDTH, default 24: signed input sample width.
REQ-003 SHALL have parameter WIDTH, default 64: accumulator and output width (>= IN_WIDTH), equal to the downstream comb width.
REQ-004 SHALL have parameter RATE_BITS, default 10: width of the decimation-rate input.
REQ-005 SHALL have port clock, input, 1: single clock; all logic on its rising edge.
REQ-006 SHALL have port reset, input, 1: asynchronous, active-high reset.
REQ-007 SHALL have port in_strobe, input, 1: in_data valid this cycle.
REQ-008 SHALL have port in_data, input, IN_WIDTH, signed: input sample.
REQ-009 SHALL have port rate, input, RATE_BITS, unsigned: decimation factor R.
REQ-010 SHALL have port out_strobe, output, 1: one-cycle pulse marking a decimated sample; drives the comb-chain strobe.
REQ-011 SHALL have port out_data, output, WIDTH, signed: decimated integrator output, fed to the first comb stage.

Function
REQ-012 SHALL sign-extend in_data to WIDTH before the first integrator.
REQ-013 SHALL update every integrator only on clock edges with in_strobe high; otherwise all state holds.
REQ-014 SHALL pipeline the integrators: stage 0 <= stage 0 + extended in_data; stage k <= stage k + stage k-1's registered (pre-edge) value.
REQ-015 SHALL use modulo-2^WIDTH two's-complement arithmetic, with no saturation and no overflow flag; wrap-around is required for correct CIC operation.
REQ-016 SHALL hold a decimation counter cnt in 0..R_act-1, advanced on in_strobe and wrapping to 0 after R_act-1.
REQ-017 SHALL latch R_act from rate only when cnt wraps (and at reset release); a rate change mid-frame takes effect from the next frame.
REQ-018 SHALL treat rate of 0 or 1 as R_act = 1, so every in_strobe produces an output.
REQ-019 SHALL, on an in_strobe edge where cnt == R_act-1, load out_data with the last stage's pre-edge value and assert out_strobe.
REQ-020 SHALL keep out_strobe high for exactly one clock and hold out_data stable until the next output event.
REQ-021 SHALL keep output spacing >= 1 clock, since one in_strobe yields at most one out_strobe; back-to-back in_strobe every cycle is legal.
REQ-022 SHALL have output latency of 1 clock from the qualifying in_strobe edge to out_strobe/out_data.

Reset
REQ-023 SHALL, on reset assertion, asynchronously clear all integrators, cnt, out_data and out_strobe to 0, and set R_act to the current rate, clamped per REQ-018.
REQ-024 SHALL, on reset mid-frame, abandon the partial frame with no out_strobe; the first frame after release is a full R_act in_strobes.

Configuration
REQ-025 SHALL support macro CIC_INT_INREG_EN: when defined, in_strobe and in_data are registered before the first integrator, adding 1 clock of latency (total 2 clocks, REQ-022 becomes 2); when undefined, the input feeds stage 0 directly (latency 1).

Structure
REQ-026 SHALL place in shared package cic_pkg: the default WIDTH/IN_WIDTH/STAGES constants, and the function computing the required WIDTH = IN_WIDTH + STAGES*ceil(log2(R_max)).
REQ-027 SHALL use one sub-module, cic_integrator (single strobe-gated accumulator with asynchronous reset), instantiated STAGES times via generate.

Verification
REQ-028 SHALL test: STAGES=1, rate=4, in_data=1 on every cycle -> out_strobe every 4th clock; out_data sequence 3, 7, 11, 15 (step 4).
REQ-029 SHALL test: STAGES=1, WIDTH=8, rate=2, in_data=100 on every cycle -> out_data wraps mod 256 (100, 44, 244, ...), and downstream comb differences are constantly 200 mod 256 (-56 signed).
REQ-030 SHALL test: rate changed 4->8 after the 2nd in_strobe of a frame -> the current frame still ends after 4 strobes, and the next frame uses 8.
REQ-031 SHALL test: in_strobe asserted only every 3rd clock, rate=2 -> out_strobe every 6 clocks, with values identical to the continuous-strobe case.
REQ-032 SHALL test: reset pulsed after 3 of 4 strobes -> outputs 0 immediately with no out_strobe; the next out_strobe comes after 4 further strobes with out_data = 3 (in_data=1, STAGES=1).
REQ-033 SHALL test: STAGES=5, rate=1, impulse in_data=1 then 0 -> out_data follows the binomial sequence 0, 1, 5, 15, 35, 70, ...; with CIC_INT_INREG_EN defined, the same sequence arrives 1 clock later.
